imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Shares the single-port, synchronous-read instruction memory between two requesters: the core fetch unit (read-only) and the program loader/debug port (read/write). It arbitrates requests, converts byte addresses to word indices, range- and alignment-checks them, drives the memory port, and routes the one-cycle-late read data back to the winning requester. It sits between the fetch stage and the instruction memory array.

## Interface
- `DEPTH`, 256: memory depth in 32-bit words; `IDX_W = $clog2(DEPTH)`.
- `BURST_MAX`, 4: consecutive loader grants allowed while fetch waits. Used only with the guard enabled.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `f_req_valid` in 1, `f_req_ready` out 1, `f_req_addr` in 32: fetch request, byte address.
- `f_flush` in 1: kills the fetch response due this cycle and blocks a fetch grant this cycle.
- `f_rsp_valid` out 1, `f_rsp_data` out 32, `f_rsp_err` out 1: fetch response; no backpressure.
- `l_hold` in 1: loader owns memory exclusively; fetch is never granted.
- `l_req_valid` in 1, `l_req_ready` out 1, `l_req_we` in 1, `l_req_addr` in 32, `l_req_wdata` in 32: loader request.
- `l_rsp_valid` out 1, `l_rsp_data` out 32, `l_rsp_err` out 1: loader response; also acknowledges writes.
- `mem_en` out 1, `mem_we` out 1, `mem_addr` out IDX_W, `mem_wdata` out 32: memory command.
- `mem_rdata` in 32: memory read data, valid the cycle after `mem_en`.

## Operation
- Handshake: a request is accepted when valid and ready are both high. At most one grant per cycle. The ready signals are combinational from the valids, `l_hold`, `f_flush` and the starvation counter.
- Priority: the loader wins over fetch by default. With `l_hold`=1, `f_req_ready`=0. With `f_flush`=1, `f_req_ready`=0.
- Address check: `idx = addr[IDX_W+1:2]`.
  - A request is bad if `addr[1:0]!=0` or `addr[31:2] >= DEPTH`.
  - A bad request is still accepted, but `mem_en` stays 0. Its response is error=1, data=0.
- Memory command: driven combinationally in the grant cycle.
  - Good request: `mem_en`=1, `mem_we`=`l_req_we` for the loader and 0 for fetch, `mem_addr`=idx, `mem_wdata`=`l_req_wdata`.
  - No grant: `mem_en`=0, `mem_we`=0; `mem_addr` and `mem_wdata` are don't-care.
- Response tracking: a registered pending record {owner, err, is_write} is loaded on each grant.
  - In the next cycle the owner's `rsp_valid` is 1.
  - `rsp_data` = `mem_rdata` for a good read, otherwise 0.
  - The other requester's `rsp_valid` is 0 and its `rsp_data` is 0.
- Flush: `f_rsp_valid` = fetch_pending & ~`f_flush`. A cancelled response is dropped, not delayed.
- State machine (tracker): IDLE → F_RSP on a fetch grant, IDLE → L_RSP on a loader grant. From F_RSP or L_RSP, the next state is F_RSP or L_RSP if another grant occurs in the same cycle, otherwise IDLE. Back-to-back grants are allowed, giving full throughput.

## Timing
- Latency: grant in cycle N, response in cycle N+1. Sustained rate is 1 request per cycle.
- Reset values (while `rst`=1):
  - All outputs are 0, including both ready signals.
  - The tracker is IDLE and the starvation counter is 0.
  - An in-flight response is discarded.
- After `rst` deasserts, grants may occur in the first cycle.
- Simultaneous valids: the loader is granted unless the starvation guard forces fetch.
- Writes: memory is updated at the end of the grant cycle. A read of the same index granted in cycle N+1 returns the new data.

## Configuration
- `IMEM_ARB_STARVE_GUARD_EN` defined:
  - A counter counts consecutive loader grants that occur while `f_req_valid`=1 and `l_hold`=0.
  - When the count equals `BURST_MAX` and both requesters are valid, fetch is granted and `l_req_ready`=0.
  - The counter clears on any fetch grant, or when `f_req_valid`=0 or `l_hold`=1.
- Not defined: strict loader priority, no counter logic, `BURST_MAX` ignored.

## Test plan
- Fetch read: preload word 3 = 0x00000013; fetch addr 0x0C → next cycle `f_rsp_valid`=1, data 0x00000013, err 0.
- Loader write then fetch read: loader writes 0xDEADBEEF to 0x20 (`l_rsp_valid`=1, data 0); fetch 0x20 in the next cycle → 0xDEADBEEF.
- Errors: fetch 0x06 → `mem_en`=0, next cycle err=1, data 0. Loader 0x400 with DEPTH=256 → err=1.
- Contention with the guard enabled and BURST_MAX=4, both valid continuously: loader granted 4 cycles, fetch 1, loader 4, and so on. With the guard disabled: fetch never granted.
- Flush and hold: a fetch granted in cycle N with `f_flush`=1 in N+1 → `f_rsp_valid`=0 in N+1 and `f_req_ready`=0 in N+1. With `l_hold`=1 → `f_req_ready` stays 0.
- Reset mid-operation: a loader read granted, then `rst` asserted in the same cycle → no `l_rsp_valid`, all outputs 0 immediately.

Source files
------------

// File: rtl/imem_arbiter_if.sv
// Bus bundle between the instruction-memory arbiter, its two requesters
// (fetch, loader/debug) and the single-port synchronous-read memory.
// slave: arbiter side. master: requester/memory side.
interface imem_arbiter_if #(
  parameter int DEPTH = 256
) ();
  localparam int IDX_W = $clog2(DEPTH);

  // fetch
  logic             f_req_valid;
  logic             f_req_ready;
  logic [31:0]      f_req_addr;
  logic             f_flush;
  logic             f_rsp_valid;
  logic [31:0]      f_rsp_data;
  logic             f_rsp_err;
  // loader / debug
  logic             l_hold;
  logic             l_req_valid;
  logic             l_req_ready;
  logic             l_req_we;
  logic [31:0]      l_req_addr;
  logic [31:0]      l_req_wdata;
  logic             l_rsp_valid;
  logic [31:0]      l_rsp_data;
  logic             l_rsp_err;
  // memory port
  logic             mem_en;
  logic             mem_we;
  logic [IDX_W-1:0] mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  modport slave (
    input  f_req_valid, f_req_addr, f_flush,
    input  l_hold, l_req_valid, l_req_we, l_req_addr, l_req_wdata,
    input  mem_rdata,
    output f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
    output l_req_ready, l_rsp_valid, l_rsp_data, l_rsp_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output f_req_valid, f_req_addr, f_flush,
    output l_hold, l_req_valid, l_req_we, l_req_addr, l_req_wdata,
    output mem_rdata,
    input  f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
    input  l_req_ready, l_rsp_valid, l_rsp_data, l_rsp_err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one synchronous-read instruction memory between the
// fetch unit (read-only) and the loader/debug port (read/write). Loader has
// priority; one grant per cycle; responses return exactly one cycle later.
// Optional starvation guard: define IMEM_ARB_STARVE_GUARD_EN to force a fetch
// grant after BURST_MAX consecutive loader grants while fetch waits.
module imem_arbiter #(
  parameter int DEPTH     = 256,
  parameter int BURST_MAX = 4
) (
  input logic           clk,
  input logic           rst,
  imem_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, F_RSP, L_RSP} trk_e;

  trk_e             state_q, state_d;
  logic             err_q, err_d;
  logic             wr_q, wr_d;
  logic             f_bad, l_bad;
  logic             force_f;
  logic             f_rdy, l_rdy;
  logic             f_gnt, l_gnt;
  logic             mem_en, mem_we;
  logic [IDX_W-1:0] mem_addr;
  logic [31:0]      mem_wdata;

  // Misaligned or beyond the array: accepted, but never reaches memory.
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH));
  endfunction

  assign f_bad = addr_bad(bus.f_req_addr);
  assign l_bad = addr_bad(bus.l_req_addr);

`ifdef IMEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(BURST_MAX + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Fetch is forced only when it can actually be granted this cycle.
  assign force_f = (cnt_q == CNT_W'(BURST_MAX)) && bus.f_req_valid &&
                   bus.l_req_valid && !bus.l_hold && !bus.f_flush;

  // Count loader grants that overtake a waiting, non-held fetch.
  always_comb begin
    cnt_d = cnt_q;
    if (!bus.f_req_valid || bus.l_hold || f_gnt)
      cnt_d = '0;
    else if (l_gnt && cnt_q != CNT_W'(BURST_MAX))
      cnt_d = cnt_q + 1'b1;
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign force_f = 1'b0;
`endif

  // Readies: loader first unless forced; everything blocked during reset.
  always_comb begin
    f_rdy = 1'b0;
    l_rdy = 1'b0;
    if (!rst) begin
      l_rdy = !force_f;
      f_rdy = !bus.l_hold && !bus.f_flush && (!bus.l_req_valid || force_f);
    end
  end

  assign f_gnt = bus.f_req_valid && f_rdy;
  assign l_gnt = bus.l_req_valid && l_rdy;

  // Memory command for the winner, driven in the grant cycle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (l_gnt) begin
      mem_en    = !l_bad;
      mem_we    = !l_bad && bus.l_req_we;
      mem_addr  = bus.l_req_addr[IDX_W+1:2];
      mem_wdata = bus.l_req_wdata;
    end else if (f_gnt) begin
      mem_en    = !f_bad;
      mem_addr  = bus.f_req_addr[IDX_W+1:2];
    end
  end

  // Tracker next state: remember owner/err/write of this cycle's grant.
  always_comb begin
    state_d = IDLE;
    err_d   = 1'b0;
    wr_d    = 1'b0;
    if (l_gnt) begin
      state_d = L_RSP;
      err_d   = l_bad;
      wr_d    = bus.l_req_we;
    end else if (f_gnt) begin
      state_d = F_RSP;
      err_d   = f_bad;
    end
  end

  // Pending-response record; reset drops anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
    end
  end

  assign bus.f_req_ready = f_rdy;
  assign bus.l_req_ready = l_rdy;
  assign bus.mem_en      = mem_en;
  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;

  // A flushed fetch response is dropped outright, data included.
  assign bus.f_rsp_valid = (state_q == F_RSP) && !bus.f_flush;
  assign bus.f_rsp_err   = bus.f_rsp_valid && err_q;
  assign bus.f_rsp_data  = (bus.f_rsp_valid && !err_q) ? bus.mem_rdata : 32'h0;

  assign bus.l_rsp_valid = (state_q == L_RSP);
  assign bus.l_rsp_err   = bus.l_rsp_valid && err_q;
  assign bus.l_rsp_data  = (bus.l_rsp_valid && !err_q && !wr_q) ? bus.mem_rdata : 32'h0;
endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed stimulus, expected responses queued per
// requester and checked by an independent negedge monitor.
module tb_imem_arbiter;
  localparam int DEPTH     = 256;
  localparam int BURST_MAX = 4;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t fq[$];
  exp_t lq[$];
  logic [31:0] mem [DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_arbiter_if #(.DEPTH(DEPTH)) bus ();

  imem_arbiter #(.DEPTH(DEPTH), .BURST_MAX(BURST_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // single-port synchronous-read memory
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // response monitor / scoreboard
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (bus.f_rsp_valid) begin
        n_chk++;
        if (fq.size() == 0) begin
          n_fail++;
          $display("FAIL f_rsp unexpected: got data %h err %b, none queued", bus.f_rsp_data, bus.f_rsp_err);
        end else begin
          n_chk--;
          e = fq.pop_front();
          chk("f_rsp cycle", 32'(cyc), 32'(e.due));
          chk("f_rsp_data", bus.f_rsp_data, e.data);
          chk("f_rsp_err", 32'(bus.f_rsp_err), 32'(e.err));
        end
      end else if (fq.size() != 0 && fq[0].due <= cyc) begin
        n_chk++; n_fail++;
        $display("FAIL f_rsp missing: got no response expected data %h at cycle %0d", fq[0].data, fq[0].due);
        void'(fq.pop_front());
      end else begin
        chk("f idle data/err", {bus.f_rsp_data[31:1], bus.f_rsp_data[0] | bus.f_rsp_err}, 32'h0);
      end

      if (bus.l_rsp_valid) begin
        n_chk++;
        if (lq.size() == 0) begin
          n_fail++;
          $display("FAIL l_rsp unexpected: got data %h err %b, none queued", bus.l_rsp_data, bus.l_rsp_err);
        end else begin
          n_chk--;
          e = lq.pop_front();
          chk("l_rsp cycle", 32'(cyc), 32'(e.due));
          chk("l_rsp_data", bus.l_rsp_data, e.data);
          chk("l_rsp_err", 32'(bus.l_rsp_err), 32'(e.err));
        end
      end else if (lq.size() != 0 && lq[0].due <= cyc) begin
        n_chk++; n_fail++;
        $display("FAIL l_rsp missing: got no response expected data %h at cycle %0d", lq[0].data, lq[0].due);
        void'(lq.pop_front());
      end else begin
        chk("l idle data/err", {bus.l_rsp_data[31:1], bus.l_rsp_data[0] | bus.l_rsp_err}, 32'h0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.f_req_valid = 1'b0;
    bus.f_req_addr  = 32'h0;
    bus.f_flush     = 1'b0;
    bus.l_hold      = 1'b0;
    bus.l_req_valid = 1'b0;
    bus.l_req_we    = 1'b0;
    bus.l_req_addr  = 32'h0;
    bus.l_req_wdata = 32'h0;
  endtask

  // Issue one fetch (called at posedge+1), check grant-cycle command.
  task automatic do_fetch(input string nm, input logic [31:0] a, input logic [31:0] d, input logic err);
    bus.f_req_valid = 1'b1;
    bus.f_req_addr  = a;
    #2;
    chk({nm, " f_req_ready"}, 32'(bus.f_req_ready), 32'd1);
    chk({nm, " mem_en"}, 32'(bus.mem_en), 32'(!err));
    chk({nm, " mem_we"}, 32'(bus.mem_we), 32'd0);
    if (!err) chk({nm, " mem_addr"}, 32'(bus.mem_addr), 32'(a[9:2]));
    fq.push_back('{d, err, cyc + 1});
    step();
    bus.f_req_valid = 1'b0;
  endtask

  // Issue one loader request (called at posedge+1).
  task automatic do_load(input string nm, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] d, input logic err);
    bus.l_req_valid = 1'b1;
    bus.l_req_we    = we;
    bus.l_req_addr  = a;
    bus.l_req_wdata = wd;
    #2;
    chk({nm, " l_req_ready"}, 32'(bus.l_req_ready), 32'd1);
    chk({nm, " mem_en"}, 32'(bus.mem_en), 32'(!err));
    chk({nm, " mem_we"}, 32'(bus.mem_we), 32'(we && !err));
    if (!err) chk({nm, " mem_addr"}, 32'(bus.mem_addr), 32'(a[9:2]));
    if (!err && we) chk({nm, " mem_wdata"}, bus.mem_wdata, wd);
    lq.push_back('{d, err, cyc + 1});
    step();
    bus.l_req_valid = 1'b0;
    bus.l_req_we    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic expf;
    idle();
    // reset with both requesters asserting: every output must be 0
    bus.f_req_valid = 1'b1; bus.f_req_addr = 32'h0C;
    bus.l_req_valid = 1'b1; bus.l_req_addr = 32'h20;
    @(negedge clk);
    chk("rst f_req_ready", 32'(bus.f_req_ready), 32'd0);
    chk("rst l_req_ready", 32'(bus.l_req_ready), 32'd0);
    chk("rst mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst f_rsp_valid", 32'(bus.f_rsp_valid), 32'd0);
    chk("rst l_rsp_valid", 32'(bus.l_rsp_valid), 32'd0);
    step();
    idle();
    rst = 1'b0;

    // grant in the very first cycle after reset; preload word 3
    do_load("ld wr 0x0C", 1'b1, 32'h0C, 32'h0000_0013, 32'h0, 1'b0);
    do_fetch("f rd 0x0C", 32'h0C, 32'h0000_0013, 1'b0);
    // write then back-to-back fetch of the same word
    do_load("ld wr 0x20", 1'b1, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0);
    do_fetch("f rd 0x20", 32'h20, 32'hDEAD_BEEF, 1'b0);
    do_load("ld rd 0x20", 1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b0);
    // last valid word, then errors
    do_load("ld wr 0x3FC", 1'b1, 32'h3FC, 32'hA5A5_0F0F, 32'h0, 1'b0);
    do_load("ld rd 0x3FC", 1'b0, 32'h3FC, 32'h0, 32'hA5A5_0F0F, 1'b0);
    do_fetch("f misalign 0x06", 32'h06, 32'h0, 1'b1);
    do_load("ld rd 0x400", 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
    do_load("ld wr 0x400", 1'b1, 32'h400, 32'h1234_5678, 32'h0, 1'b1);
    do_load("ld rd 0x0E", 1'b0, 32'h0E, 32'h0, 32'h0, 1'b1);
    do_load("ld rd 0x0C after bad wr", 1'b0, 32'h0C, 32'h0, 32'h0000_0013, 1'b0);

    // flush: fetch granted in N, flush in N+1 drops it and blocks fetch
    bus.f_req_valid = 1'b1; bus.f_req_addr = 32'h0C;
    #2;
    chk("flush grant f_req_ready", 32'(bus.f_req_ready), 32'd1);
    step();
    bus.f_flush = 1'b1;
    #2;
    chk("flush f_rsp_valid", 32'(bus.f_rsp_valid), 32'd0);
    chk("flush f_req_ready", 32'(bus.f_req_ready), 32'd0);
    chk("flush mem_en", 32'(bus.mem_en), 32'd0);
    step();
    idle();

    // hold: fetch never granted, loader still served
    bus.l_hold = 1'b1;
    bus.f_req_valid = 1'b1; bus.f_req_addr = 32'h0C;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("hold f_req_ready", 32'(bus.f_req_ready), 32'd0);
      chk("hold mem_en", 32'(bus.mem_en), 32'd0);
      step();
    end
    do_load("hold ld rd 0x20", 1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b0);
    idle();
    step();

    // contention: both valid for 15 cycles
    bus.f_req_valid = 1'b1; bus.f_req_addr = 32'h0C;
    bus.l_req_valid = 1'b1; bus.l_req_addr = 32'h20; bus.l_req_we = 1'b0;
    for (int i = 0; i < 15; i++) begin
`ifdef IMEM_ARB_STARVE_GUARD_EN
      expf = ((i % (BURST_MAX + 1)) == BURST_MAX);
`else
      expf = 1'b0;
`endif
      #2;
      chk("cont f_req_ready", 32'(bus.f_req_ready), 32'(expf));
      chk("cont l_req_ready", 32'(bus.l_req_ready), 32'(!expf));
      if (expf) fq.push_back('{32'h0000_0013, 1'b0, cyc + 1});
      else      lq.push_back('{32'hDEAD_BEEF, 1'b0, cyc + 1});
      step();
    end
    idle();
    step();
    step();

    // reset arrives while a loader read is being granted
    bus.l_req_valid = 1'b1; bus.l_req_addr = 32'h20;
    #1;
    chk("rst-mid grant l_req_ready", 32'(bus.l_req_ready), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst-mid l_req_ready", 32'(bus.l_req_ready), 32'd0);
    chk("rst-mid mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst-mid l_rsp_valid", 32'(bus.l_rsp_valid), 32'd0);
    step();
    #2;
    chk("rst-mid next l_rsp_valid", 32'(bus.l_rsp_valid), 32'd0);
    idle();
    step();
    rst = 1'b0;
    #2;
    chk("post-rst l_rsp_valid", 32'(bus.l_rsp_valid), 32'd0);
    step();
    step();

    chk("fetch queue drained", 32'(fq.size()), 32'd0);
    chk("loader queue drained", 32'(lq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
